// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens, cd/token mapping, FSM states.
// Used by both the encoder and decoder sides.
package tmds_pkg;

   localparam logic [9:0] CTRL_TOK0 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOK1 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOK2 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOK3 = 10'b1010101011;

   localparam int DISP_LIMIT = 8;

   typedef enum logic [1:0] {
      SEARCH,
      SLIP,
      WAIT,
      LOCKED
   } state_e;

   function automatic logic [9:0] cd_to_tok(input logic [1:0] cd);
      logic [9:0] t;
      unique case (cd)
         2'b00: t = CTRL_TOK0;
         2'b01: t = CTRL_TOK1;
         2'b10: t = CTRL_TOK2;
         2'b11: t = CTRL_TOK3;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_decoder_if.sv
// Per-channel TMDS decoder bus: raw symbol in, decoded video/control out.
// master = deserialiser/capture side, slave = decoder.
interface tmds_decoder_if;

   logic [9:0] tmds;
   logic [7:0] vd;
   logic [1:0] cd;
   logic       vde;
   logic       locked;
   logic       bitslip;
   logic       sym_err;

   modport master (
      output tmds,
      input  vd, cd, vde, locked, bitslip, sym_err
   );

   modport slave (
      input  tmds,
      output vd, cd, vde, locked, bitslip, sym_err
   );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token match and 8b data
// recovery (XOR/XNOR chain after optional inversion).
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] i_sym,
   output logic       o_is_ctrl,
   output logic [1:0] o_cd,
   output logic [7:0] o_vd
);

   logic [7:0] w_q;

   assign w_q = i_sym[7:0] ^ {8{i_sym[9]}};

   always_comb begin
      o_is_ctrl = 1'b0;
      o_cd      = 2'b00;
      for (int k = 0; k < 4; k++) begin
         if (i_sym == cd_to_tok(2'(k))) begin
            o_is_ctrl = 1'b1;
            o_cd      = 2'(k);
         end
      end
   end

   always_comb begin
      o_vd    = '0;
      o_vd[0] = w_q[0];
      for (int i = 1; i < 8; i++) begin
         o_vd[i] = i_sym[8] ? (w_q[i] ^ w_q[i-1])
                            : ~(w_q[i] ^ w_q[i-1]);
      end
   end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with bit-slip alignment search and lock tracking.
// Optional running-disparity check: define TMDS_DISPARITY_CHECK_EN.
module tmds_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN      = 16,
   parameter int SEARCH_WINDOW = 4096,
   parameter int SLIP_WAIT     = 16,
   parameter int LOCK_TIMEOUT  = 65536
) (
   input  logic           clk,
   input  logic           rst,
   tmds_decoder_if.slave  bus
);

   localparam int RUN_W = $clog2(CTRL_RUN + 1);
   localparam int WIN_W = $clog2(SEARCH_WINDOW);
   localparam int WT_W  = $clog2(SLIP_WAIT);
   localparam int IDL_W = $clog2(LOCK_TIMEOUT);

   logic             w_is_ctrl;
   logic [1:0]       w_cd;
   logic [7:0]       w_vd;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_nxt;
   logic [WIN_W-1:0] r_win;
   logic [WIN_W-1:0] w_win_nxt;
   logic [WT_W-1:0]  r_wait;
   logic [WT_W-1:0]  w_wait_nxt;
   logic [IDL_W-1:0] r_idle;
   logic [IDL_W-1:0] w_idle_nxt;

   logic [7:0]       r_vd;
   logic [1:0]       r_cd;
   logic             r_vde;
   logic             r_err;
   logic             w_glitch;
   logic             w_disp_err;

   tmds_symbol_decode u_dec (
      .i_sym     (bus.tmds),
      .o_is_ctrl (w_is_ctrl),
      .o_cd      (w_cd),
      .o_vd      (w_vd)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = '0;
      w_wait_nxt  = '0;
      w_idle_nxt  = '0;
      if (!w_is_ctrl)
         w_run_nxt = '0;
      else if (r_run == RUN_W'(CTRL_RUN))
         w_run_nxt = r_run;
      else
         w_run_nxt = r_run + 1'b1;

      unique case (r_state)
         SEARCH: begin
            // lock has priority over an expiring window
            if (r_run == RUN_W'(CTRL_RUN))
               w_state_nxt = LOCKED;
            else if (r_win == WIN_W'(SEARCH_WINDOW - 1))
               w_state_nxt = SLIP;
            else
               w_win_nxt = r_win + 1'b1;
         end
         SLIP: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            w_run_nxt = '0;
            if (r_wait == WT_W'(SLIP_WAIT - 1))
               w_state_nxt = SEARCH;
            else
               w_wait_nxt = r_wait + 1'b1;
         end
         LOCKED: begin
            if (!w_is_ctrl) begin
               if (r_idle == IDL_W'(LOCK_TIMEOUT - 1))
                  w_state_nxt = SEARCH;
               else
                  w_idle_nxt = r_idle + 1'b1;
            end
         end
         default: w_state_nxt = SEARCH;
      endcase
   end

   // data right after a lone control token means blanking was glitched
   assign w_glitch = (r_state == LOCKED) && !w_is_ctrl &&
                     (r_run == RUN_W'(1));

`ifdef TMDS_DISPARITY_CHECK_EN
   logic signed [4:0] r_acc;
   logic signed [4:0] w_acc_sum;
   logic [3:0]        w_ones;

   assign w_ones    = 4'($countones(bus.tmds));
   assign w_acc_sum = r_acc + $signed({1'b0, w_ones}) - 5'sd5;
   assign w_disp_err = !w_is_ctrl &&
      ((w_acc_sum >  $signed(5'(DISP_LIMIT))) ||
       (w_acc_sum < -$signed(5'(DISP_LIMIT))));

   always_ff @(posedge clk) begin
      if (rst)
         r_acc <= '0;
      else if (w_is_ctrl || w_disp_err)
         r_acc <= '0;
      else
         r_acc <= w_acc_sum;
   end
`else
   assign w_disp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SEARCH;
         r_run   <= '0;
         r_win   <= '0;
         r_wait  <= '0;
         r_idle  <= '0;
         r_vd    <= '0;
         r_cd    <= '0;
         r_vde   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_win   <= w_win_nxt;
         r_wait  <= w_wait_nxt;
         r_idle  <= w_idle_nxt;
         if (w_is_ctrl)
            r_cd <= w_cd;
         else
            r_vd <= w_vd;
         r_vde   <= !w_is_ctrl && (w_state_nxt == LOCKED);
         r_err   <= w_glitch | w_disp_err;
      end
   end

   assign bus.vd      = r_vd;
   assign bus.cd      = r_cd;
   assign bus.vde     = r_vde;
   assign bus.sym_err = r_err;
   assign bus.locked  = (r_state == LOCKED);
   assign bus.bitslip = (r_state == SLIP);

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder (scaled-down window/timeout).
// Disparity expectations follow TMDS_DISPARITY_CHECK_EN.
module tb_tmds_decoder;
   import tmds_pkg::*;

   localparam int CR  = 16;
   localparam int SW  = 128;
   localparam int SWT = 16;
   localparam int LT  = 512;

   typedef struct packed {
      logic       vde;
      logic [1:0] cd;
      logic [7:0] vd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   tmds_decoder_if bus();

   tmds_decoder #(
      .CTRL_RUN      (CR),
      .SEARCH_WINDOW (SW),
      .SLIP_WAIT     (SWT),
      .LOCK_TIMEOUT  (LT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic is_tok(input logic [9:0] s);
      return (s == 10'b1101010100) || (s == 10'b0010101011) ||
             (s == 10'b0101010100) || (s == 10'b1010101011);
   endfunction

   function automatic logic [1:0] tok_cd(input logic [9:0] s);
      case (s)
         10'b0010101011: return 2'b01;
         10'b0101010100: return 2'b10;
         10'b1010101011: return 2'b11;
         default:        return 2'b00;
      endcase
   endfunction

   function automatic logic [7:0] ref_vd(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] r;
      q = s[7:0] ^ {8{s[9]}};
      r[0] = q[0];
      for (int i = 1; i < 8; i++)
         r[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return r;
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] x, input int n);
      logic [9:0] y;
      y = x;
      for (int i = 0; i < n; i++) y = {y[8:0], y[9]};
      return y;
   endfunction

   task automatic step(input logic [9:0] s);
      bus.tmds = s;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(CTRL_TOK0);
      step(CTRL_TOK0);
      rst = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      logic [14:0] got;
      got = {bus.vd, bus.cd, bus.vde, bus.locked, bus.bitslip, bus.sym_err};
      n_total++;
      if (got !== 15'h0) begin
         n_bad++;
         $display("FAIL %s outs got=%h exp=0", tag, got);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if (bus.vd !== 8'h00) begin
         n_bad++; $display("FAIL rst_vd got=%h exp=00", bus.vd);
      end
      n_total++;
      if (bus.cd !== 2'b00) begin
         n_bad++; $display("FAIL rst_cd got=%b exp=00", bus.cd);
      end
      n_total++;
      if (bus.vde !== 1'b0) begin
         n_bad++; $display("FAIL rst_vde got=%b exp=0", bus.vde);
      end
      n_total++;
      if (bus.locked !== 1'b0) begin
         n_bad++; $display("FAIL rst_locked got=%b exp=0", bus.locked);
      end
      n_total++;
      if (bus.bitslip !== 1'b0) begin
         n_bad++; $display("FAIL rst_bitslip got=%b exp=0", bus.bitslip);
      end
      n_total++;
      if (bus.sym_err !== 1'b0) begin
         n_bad++; $display("FAIL rst_sym_err got=%b exp=0", bus.sym_err);
      end
   endtask

   task automatic test_lock();
      int first;
      int slips;
      first = -1;
      slips = 0;
      for (int k = 1; k <= 20; k++) begin
         step(CTRL_TOK0);
         if (bus.bitslip) slips++;
         if (bus.locked === 1'b1 && first < 0) first = k;
      end
      n_total++;
      if (first < 17 || first > 18) begin
         n_bad++; $display("FAIL lock_cycle got=%0d exp=17..18", first);
      end
      n_total++;
      if (slips != 0) begin
         n_bad++; $display("FAIL lock_slips got=%0d exp=0", slips);
      end
      n_total++;
      if (bus.cd !== 2'b00 || bus.vde !== 1'b0) begin
         n_bad++;
         $display("FAIL lock_ctrl got=cd%b/vde%b exp=cd00/vde0",
                  bus.cd, bus.vde);
      end
   endtask

   task automatic test_decode();
      logic [7:0] mv;
      logic [1:0] mc;
      logic [9:0] s;
      exp_t       e;
      exp_t       g;
      mv = 8'h00;
      mc = 2'b00;
      for (int k = 0; k < 42; k++) begin
         if (k == 0)
            s = 10'h100;
         else if (k == 1)
            s = 10'h200;
         else if ($urandom_range(0, 3) == 0)
            s = cd_to_tok(2'($urandom_range(0, 3)));
         else
            s = 10'($urandom());
         if (is_tok(s)) mc = tok_cd(s);
         else           mv = ref_vd(s);
         e.vde = !is_tok(s);
         e.cd  = mc;
         e.vd  = mv;
         sb.push_back(e);
         step(s);
         e = sb.pop_front();
         g = {bus.vde, bus.cd, bus.vd};
         n_total++;
         if (g !== e) begin
            n_bad++;
            $display("FAIL decode[%0d] sym=%h got=%h exp=%h", k, s, g, e);
         end
      end
   endtask

   task automatic test_glitch();
      step(CTRL_TOK0);
      step(CTRL_TOK0);
      step(CTRL_TOK0);
      step(10'h100);
      n_total++;
      if (bus.sym_err !== 1'b0) begin
         n_bad++; $display("FAIL glitch_clean got=%b exp=0", bus.sym_err);
      end
      step(CTRL_TOK1);
      step(10'h100);
      n_total++;
      if (bus.sym_err !== 1'b1) begin
         n_bad++; $display("FAIL glitch_pulse got=%b exp=1", bus.sym_err);
      end
      step(10'h100);
      n_total++;
      if (bus.sym_err !== 1'b0 || bus.locked !== 1'b1) begin
         n_bad++;
         $display("FAIL glitch_after got=err%b/lk%b exp=err0/lk1",
                  bus.sym_err, bus.locked);
      end
   endtask

   task automatic test_disparity();
      logic exp2;
`ifdef TMDS_DISPARITY_CHECK_EN
      exp2 = 1'b1;
`else
      exp2 = 1'b0;
`endif
      step(CTRL_TOK0);
      step(CTRL_TOK0);
      step(10'h3FF);
      n_total++;
      if (bus.sym_err !== 1'b0) begin
         n_bad++; $display("FAIL disp_w1 got=%b exp=0", bus.sym_err);
      end
      step(10'h3FF);
      n_total++;
      if (bus.sym_err !== exp2) begin
         n_bad++; $display("FAIL disp_w2 got=%b exp=%b", bus.sym_err, exp2);
      end
      step(10'h3FF);
      n_total++;
      if (bus.sym_err !== 1'b0) begin
         n_bad++; $display("FAIL disp_w3 got=%b exp=0", bus.sym_err);
      end
   endtask

   task automatic test_timeout();
      int sl;
      step(CTRL_TOK0);
      for (int k = 1; k < LT; k++) step(10'h100);
      n_total++;
      if (bus.locked !== 1'b1 || bus.vde !== 1'b1) begin
         n_bad++;
         $display("FAIL tmo_pre got=lk%b/vde%b exp=lk1/vde1",
                  bus.locked, bus.vde);
      end
      step(10'h100);
      n_total++;
      if (bus.locked !== 1'b0 || bus.vde !== 1'b0) begin
         n_bad++;
         $display("FAIL tmo_drop got=lk%b/vde%b exp=lk0/vde0",
                  bus.locked, bus.vde);
      end
      sl = 0;
      for (int k = 1; k < SW; k++) begin
         step(10'h100);
         if (bus.bitslip) sl++;
      end
      n_total++;
      if (sl != 0) begin
         n_bad++; $display("FAIL tmo_early_slip got=%0d exp=0", sl);
      end
      step(10'h100);
      n_total++;
      if (bus.bitslip !== 1'b1) begin
         n_bad++; $display("FAIL tmo_slip got=%b exp=1", bus.bitslip);
      end
      step(10'h200);
      n_total++;
      if (bus.bitslip !== 1'b0) begin
         n_bad++; $display("FAIL slip_width got=%b exp=0", bus.bitslip);
      end
   endtask

   task automatic test_reset_in_wait();
      int sl;
      step(10'h200);
      rst = 1'b1;
      step(10'h200);
      chk_zero("wait_rst");
      rst = 1'b0;
      sl = 0;
      for (int k = 1; k < SW; k++) begin
         step(10'h200);
         if (bus.bitslip) sl++;
      end
      n_total++;
      if (sl != 0) begin
         n_bad++; $display("FAIL wait_rst_slip got=%0d exp=0", sl);
      end
      step(10'h200);
      n_total++;
      if (bus.bitslip !== 1'b1) begin
         n_bad++; $display("FAIL wait_rst_window got=%b exp=1", bus.bitslip);
      end
   endtask

   task automatic test_slip_align();
      int t[$];
      int r;
      int budget;
      do_reset();
      r = 3;
      budget = 4 * (SW + SWT + 1) + 100;
      for (int k = 0; k < budget && bus.locked !== 1'b1; k++) begin
         step(rotl(CTRL_TOK0, r));
         if (bus.bitslip === 1'b1) begin
            t.push_back(cyc);
            if (r > 0) r--;
         end
      end
      n_total++;
      if (t.size() != 3) begin
         n_bad++; $display("FAIL align_pulses got=%0d exp=3", t.size());
      end
      if (t.size() == 3) begin
         for (int i = 1; i < 3; i++) begin
            n_total++;
            if (t[i] - t[i-1] != SW + SWT + 1) begin
               n_bad++;
               $display("FAIL align_gap%0d got=%0d exp=%0d",
                        i, t[i] - t[i-1], SW + SWT + 1);
            end
         end
      end
      n_total++;
      if (bus.locked !== 1'b1 || bus.cd !== 2'b00) begin
         n_bad++;
         $display("FAIL align_lock got=lk%b/cd%b exp=lk1/cd00",
                  bus.locked, bus.cd);
      end
   endtask

   initial begin
      bus.tmds = '0;
      test_reset();
      test_lock();
      test_decode();
      test_glitch();
      test_disparity();
      test_timeout();
      test_reset_in_wait();
      test_slip_align();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
